// File: rtl/core_bus_arbiter_pkg.sv
// Shared encodings for the three-core bus arbiter: grant one-hots, owner indices, FSM states.
// Also holds small helpers used by the round-robin picker.
package arb_pkg;

    localparam logic [2:0] GNT_N    = 3'b001;
    localparam logic [2:0] GNT_K    = 3'b010;
    localparam logic [2:0] GNT_M    = 3'b100;
    localparam logic [2:0] GNT_NONE = 3'b000;

    localparam logic [1:0] OWN_N    = 2'd0;
    localparam logic [1:0] OWN_K    = 2'd1;
    localparam logic [1:0] OWN_M    = 2'd2;
    localparam logic [1:0] OWN_NONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    // Reduce a value in 0..4 modulo 3.
    function automatic logic [1:0] wrap3(input logic [2:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction

    function automatic logic [2:0] own2gnt(input logic [1:0] o);
        logic [2:0] g;
        case (o)
            OWN_N:   g = GNT_N;
            OWN_K:   g = GNT_K;
            OWN_M:   g = GNT_M;
            default: g = GNT_NONE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/core_bus_arbiter_rr_pick3.sv
// Combinational round-robin picker over three requesters.
// Search begins one past the previous winner and wraps N -> K -> M -> N.
module rr_pick3
    import arb_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] last_i,
    output logic [1:0] win_idx_o,
    output logic [2:0] win_oh_o
);

    logic [1:0] start;
    logic [1:0] idx;

    always_comb begin
        case (last_i)
            OWN_N:   start = OWN_K;
            OWN_K:   start = OWN_M;
            default: start = OWN_N;
        endcase
        win_idx_o = OWN_NONE;
        win_oh_o  = GNT_NONE;
        idx       = OWN_N;
        // Walk from lowest priority to highest so the closest candidate is written last.
        for (int i = 2; i >= 0; i--) begin
            idx = wrap3({1'b0, start} + 3'(i));
            if (req_i[idx]) begin
                win_idx_o = idx;
                win_oh_o  = own2gnt(idx);
            end
        end
    end

endmodule

// File: rtl/core_bus_arbiter.sv
// Round-robin owner of the shared 16-bit bus with a one-cycle all-zero turnaround between owners.
// Optional hold limit enabled by defining ARB_TIMEOUT_EN.
module core_bus_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [2:0] req_i,
    input  logic [2:0] done_i,
    output logic [2:0] grant_o,
    output logic [1:0] owner_o,
    output logic       busy_o,
    output logic       timeout_o,
    output arb_state_e state_o
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("core_bus_arbiter: MAX_HOLD must lie in 2..255");
    end

    arb_state_e state_q;
    logic [2:0] grant_q;
    logic [1:0] owner_q;
    logic [1:0] last_q;
    logic       busy_q;

    logic [1:0] pick_idx_d;
    logic [2:0] pick_oh_d;
    logic       own_done;
    logic       own_req;

    rr_pick3 u_pick (
        .req_i     (req_i),
        .last_i    (last_q),
        .win_idx_o (pick_idx_d),
        .win_oh_o  (pick_oh_d)
    );

    // grant_q is one-hot in GRANT, so masking with it selects the owner's bits.
    assign own_done = |(done_i & grant_q);
    assign own_req  = |(req_i & grant_q);

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt_q;
    logic       timeout_q;
    logic       other_req;

    assign other_req = |(req_i & ~grant_q);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            grant_q    <= GNT_NONE;
            owner_q    <= OWN_NONE;
            last_q     <= OWN_M;
            busy_q     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (|req_i) begin
                        state_q    <= GRANT;
                        grant_q    <= pick_oh_d;
                        owner_q    <= pick_idx_d;
                        last_q     <= pick_idx_d;
                        busy_q     <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt_q <= 8'd0;
`endif
                    end
                end
                GRANT: begin
                    if (own_done || !own_req) begin
                        state_q <= GAP;
                        grant_q <= GNT_NONE;
                        owner_q <= OWN_NONE;
                        busy_q  <= 1'b0;
                    end
`ifdef ARB_TIMEOUT_EN
                    // >= also catches a counter that saturated before a competitor showed up.
                    else if (other_req && hold_cnt_q >= HOLD_LIM) begin
                        state_q   <= GAP;
                        grant_q   <= GNT_NONE;
                        owner_q   <= OWN_NONE;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else if (hold_cnt_q != HOLD_MAX) begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
`endif
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= GNT_NONE;
                    owner_q <= OWN_NONE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign grant_o = grant_q;
    assign owner_o = owner_q;
    assign busy_o  = busy_q;
    assign state_o = state_q;
`ifdef ARB_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed vector bench for core_bus_arbiter: table of per-cycle stimulus/expectations plus
// hand-written sequences for long hold / hold limit and asynchronous reset mid-grant.
module tb_core_bus_arbiter;
  import arb_pkg::*;

  localparam int TB_MAX_HOLD = 4;

  // clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] req = 3'b000;
  logic [2:0] done = 3'b000;
  logic [2:0] grant;
  logic [1:0] owner;
  logic busy;
  logic timeout;
  arb_state_e state;

  core_bus_arbiter #(.MAX_HOLD(TB_MAX_HOLD)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_i     (req),
    .done_i    (done),
    .grant_o   (grant),
    .owner_o   (owner),
    .busy_o    (busy),
    .timeout_o (timeout),
    .state_o   (state)
  );

  typedef struct packed {
    logic [2:0] req;
    logic [2:0] done;
    logic [2:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;
  } vec_t;

  vec_t vecs[$];
  int n_vec = 0;
  int n_err = 0;

  // scoreboard
  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int idx, input logic [2:0] g, input logic [1:0] o,
                            input logic b, input logic t);
    check({tag, ".grant"}, idx, {5'd0, grant}, {5'd0, g});
    check({tag, ".owner"}, idx, {6'd0, owner}, {6'd0, o});
    check({tag, ".busy"}, idx, {7'd0, busy}, {7'd0, b});
    check({tag, ".timeout"}, idx, {7'd0, timeout}, {7'd0, t});
  endtask

  // driver: inputs set at a falling edge, outputs sampled at the next falling edge
  task automatic step(input logic [2:0] r, input logic [2:0] d);
    req = r;
    done = d;
    @(negedge clk);
  endtask

  initial begin
    // idle, single grant, done release
    vecs.push_back('{3'b000, 3'b000, GNT_NONE, OWN_NONE, 1'b0, 1'b0});
    vecs.push_back('{3'b001, 3'b000, GNT_N,    OWN_N,    1'b1, 1'b0});
    vecs.push_back('{3'b001, 3'b000, GNT_N,    OWN_N,    1'b1, 1'b0});
    vecs.push_back('{3'b001, 3'b001, GNT_NONE, OWN_NONE, 1'b0, 1'b0});
    vecs.push_back('{3'b000, 3'b000, GNT_NONE, OWN_NONE, 1'b0, 1'b0});
    // fairness with all three requesting, 2 granted cycles each
    vecs.push_back('{3'b111, 3'b000, GNT_K,    OWN_K,    1'b1, 1'b0});
    vecs.push_back('{3'b111, 3'b000, GNT_K,    OWN_K,    1'b1, 1'b0});
    vecs.push_back('{3'b111, 3'b010, GNT_NONE, OWN_NONE, 1'b0, 1'b0});
    vecs.push_back('{3'b111, 3'b000, GNT_NONE, OWN_NONE, 1'b0, 1'b0});
    vecs.push_back('{3'b111, 3'b000, GNT_M,    OWN_M,    1'b1, 1'b0});
    vecs.push_back('{3'b111, 3'b000, GNT_M,    OWN_M,    1'b1, 1'b0});
    vecs.push_back('{3'b111, 3'b100, GNT_NONE, OWN_NONE, 1'b0, 1'b0});
    vecs.push_back('{3'b111, 3'b000, GNT_NONE, OWN_NONE, 1'b0, 1'b0});
    vecs.push_back('{3'b111, 3'b000, GNT_N,    OWN_N,    1'b1, 1'b0});
    vecs.push_back('{3'b111, 3'b000, GNT_N,    OWN_N,    1'b1, 1'b0});
    vecs.push_back('{3'b111, 3'b001, GNT_NONE, OWN_NONE, 1'b0, 1'b0});
    vecs.push_back('{3'b111, 3'b000, GNT_NONE, OWN_NONE, 1'b0, 1'b0});
    vecs.push_back('{3'b111, 3'b000, GNT_K,    OWN_K,    1'b1, 1'b0});
    // non-owner done ignored, then K drops its request
    vecs.push_back('{3'b111, 3'b100, GNT_K,    OWN_K,    1'b1, 1'b0});
    vecs.push_back('{3'b101, 3'b000, GNT_NONE, OWN_NONE, 1'b0, 1'b0});
    vecs.push_back('{3'b101, 3'b000, GNT_NONE, OWN_NONE, 1'b0, 1'b0});
    vecs.push_back('{3'b101, 3'b000, GNT_M,    OWN_M,    1'b1, 1'b0});
    // done and dropped req together: one release
    vecs.push_back('{3'b001, 3'b101, GNT_NONE, OWN_NONE, 1'b0, 1'b0});
    vecs.push_back('{3'b000, 3'b000, GNT_NONE, OWN_NONE, 1'b0, 1'b0});
    // one-edge request glitch is still granted, then released by the dropped req
    vecs.push_back('{3'b010, 3'b000, GNT_K,    OWN_K,    1'b1, 1'b0});
    vecs.push_back('{3'b000, 3'b000, GNT_NONE, OWN_NONE, 1'b0, 1'b0});
    vecs.push_back('{3'b000, 3'b000, GNT_NONE, OWN_NONE, 1'b0, 1'b0});
    vecs.push_back('{3'b000, 3'b000, GNT_NONE, OWN_NONE, 1'b0, 1'b0});
    // single requester re-granted after GAP + IDLE
    vecs.push_back('{3'b100, 3'b000, GNT_M,    OWN_M,    1'b1, 1'b0});
    vecs.push_back('{3'b100, 3'b100, GNT_NONE, OWN_NONE, 1'b0, 1'b0});
    vecs.push_back('{3'b100, 3'b000, GNT_NONE, OWN_NONE, 1'b0, 1'b0});
    vecs.push_back('{3'b100, 3'b000, GNT_M,    OWN_M,    1'b1, 1'b0});
    vecs.push_back('{3'b000, 3'b000, GNT_NONE, OWN_NONE, 1'b0, 1'b0});
    vecs.push_back('{3'b000, 3'b000, GNT_NONE, OWN_NONE, 1'b0, 1'b0});

    // reset values, asserted between edges
    #12;
    check_outs("reset", 0, GNT_NONE, OWN_NONE, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].req, vecs[i].done);
      check_outs("vec", i, vecs[i].grant, vecs[i].owner, vecs[i].busy, vecs[i].timeout);
    end

    // long hold by N while K also requests (last owner was M, so N wins)
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < TB_MAX_HOLD; c++) begin
      step(3'b011, 3'b000);
      check_outs("hold", c, GNT_N, OWN_N, 1'b1, 1'b0);
    end
    step(3'b011, 3'b000);
    check_outs("tmo_gap", 0, GNT_NONE, OWN_NONE, 1'b0, 1'b1);
    step(3'b011, 3'b000);
    check_outs("tmo_idle", 0, GNT_NONE, OWN_NONE, 1'b0, 1'b0);
    step(3'b011, 3'b000);
    check_outs("tmo_next", 0, GNT_K, OWN_K, 1'b1, 1'b0);
`else
    for (int c = 0; c < 20; c++) begin
      step(3'b011, 3'b000);
      check_outs("hold", c, GNT_N, OWN_N, 1'b1, 1'b0);
    end
    step(3'b011, 3'b001);
    check_outs("hold_rel", 0, GNT_NONE, OWN_NONE, 1'b0, 1'b0);
    step(3'b011, 3'b000);
    check_outs("hold_idle", 0, GNT_NONE, OWN_NONE, 1'b0, 1'b0);
    step(3'b011, 3'b000);
    check_outs("hold_next", 0, GNT_K, OWN_K, 1'b1, 1'b0);
`endif

    // asynchronous reset mid-grant: K currently owns the bus
    req = 3'b111;
    done = 3'b000;
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 0, GNT_NONE, OWN_NONE, 1'b0, 1'b0);
    check("async_rst.state", 0, {6'd0, state}, {6'd0, IDLE});
    @(negedge clk);
    rst_n = 1'b1;
    step(3'b111, 3'b000);
    check_outs("post_rst", 0, GNT_N, OWN_N, 1'b1, 1'b0);
    step(3'b111, 3'b001);
    check_outs("post_rst_rel", 0, GNT_NONE, OWN_NONE, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/core_bus_arbiter.md
# core_bus_arbiter

Round-robin arbiter granting one of three cores (N, K, M) ownership of the shared 16-bit data bus. Its one-hot `grant` output drives the select input of the 3-to-1 bus multiplexer directly downstream. Select `3'b001` routes N, `3'b010` routes K, `3'b100` routes M, and `3'b000` leaves the bus undriven (`z`). Grants are registered, and a mandatory one-cycle all-zero turnaround separates consecutive owners.

## Interface
Parameters:
- `MAX_HOLD`, default 16: maximum consecutive grant cycles per owner. Used only when `ARB_TIMEOUT_EN` is defined. Legal range 2..255.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in 3: bus requests. bit0 = N, bit1 = K, bit2 = M. A request is level-held until `done` or until it is dropped.
- `done` in 3: one-cycle release pulse per core. Ignored for non-owners.
- `grant` out 3: one-hot or `000`. Wired to the mux select.
- `owner` out 2: index of the current owner (0 = N, 1 = K, 2 = M). Value 3 means no owner.
- `busy` out 1: high whenever `grant != 000`.
- `timeout` out 1: one-cycle pulse when a grant is revoked by the hold limit. Tied 0 when `ARB_TIMEOUT_EN` is undefined.

## Operation
State machine states: IDLE, GRANT, GAP.

- **IDLE**
  - Stays in IDLE while `req == 000`; outputs `grant = 000`.
  - If any `req` bit is set, selects a winner by round-robin:
    - Search starts at `last_owner + 1` (mod 3) and proceeds N→K→M→N.
  - Registers the winner into `grant` and `owner`, updates `last_owner`, clears `hold_cnt`, and moves to GRANT.
- **GRANT**
  - `grant` and `owner` are held constant.
  - `hold_cnt` increments every cycle and saturates at `MAX_HOLD`.
  - Release condition: `done[owner]`, or `req[owner] == 0`. On release, move to GAP.
  - Requests from non-owners are ignored until the arbiter returns to IDLE.
- **GAP**
  - Outputs `grant = 000` and `owner = 3` for exactly one cycle (bus turnaround), then moves to IDLE.

Boundary rules:
- **After reset:** `last_owner = 2`, so N has first priority.
- **Single requester:** may be re-granted after GAP+IDLE. No starvation bypass is needed.
- **`done` and a dropped `req` in the same cycle:** treated as one release.
- **`done` from a non-owner:** ignored, with no state change.
- **`req` glitch in IDLE:** sampled only on the clock edge. A request present for one edge is granted even if dropped the next cycle; the owner then releases via the dropped-`req` rule.
- **Reset mid-GRANT:**
  - `grant` goes to `000` and `owner` to 3 immediately, without waiting for a clock edge.
  - State returns to IDLE and `hold_cnt` clears.

## Timing
- **Reset values:** `grant = 000`, `owner = 3`, `busy = 0`, `timeout = 0`.
- **Grant latency:** `req` sampled in IDLE at edge t gives `grant` valid after edge t (registered, 1 cycle).
- **Release latency:** `done` sampled at edge t gives `grant = 000` after edge t. The next grant appears after edge t+2 at the earliest (GAP, then IDLE arbitration).
- **Minimum ownership:** 1 cycle.
- **Back-to-back handover period:** 1-cycle gap plus 1-cycle IDLE arbitration. A new owner is driven 2 cycles after the previous owner's last granted cycle.
- **Output glitches:** none. `grant` and `owner` come straight from flops.

## Configuration
Macro: `ARB_TIMEOUT_EN`.
- **Defined:**
  - In GRANT, when `hold_cnt == MAX_HOLD - 1` and any other `req` bit is set, move to GAP and pulse `timeout` in the first GAP cycle.
  - The revoked owner keeps its `req` and competes again under round-robin order.
  - If `done` and the timeout fire in the same cycle, it is a normal release with no `timeout` pulse.
- **Undefined:**
  - Ownership is unbounded.
  - `hold_cnt` is not synthesized and `timeout` is constant 0.

## Structure
- **Package `arb_pkg`:**
  - Grant encodings `GNT_N = 3'b001`, `GNT_K = 3'b010`, `GNT_M = 3'b100`, `GNT_NONE = 3'b000`.
  - Owner constants `OWN_N = 0`, `OWN_K = 1`, `OWN_M = 2`, `OWN_NONE = 3`.
  - State typedef `{IDLE, GRANT, GAP}`.
- **Sub-module `rr_pick3`:** combinational round-robin picker.
  - Inputs: `req[2:0]`, `last[1:0]`.
  - Outputs: winner index and one-hot.
  - The top block holds the FSM, counter and registers.

## Test plan
1. **Reset:** assert `rst_n = 0`. Expect `grant = 000`, `owner = 3`, `busy = 0`, `timeout = 0`. Release reset with `req = 000`; outputs stay unchanged.
2. **Single grant:** `req = 001`.
   - Expect `grant = 001`, `owner = 0` one cycle later.
   - Pulse `done = 001`: next cycle `grant = 000` (GAP), then IDLE.
3. **Fairness:** hold `req = 111`; each owner pulses `done` after 2 granted cycles. Expect grant sequence 001, 010, 100, 001, with exactly one `000` cycle plus one IDLE cycle between owners.
4. **Dropped request:** owner K drops `req[1]` without `done`. Expect `grant = 000` the next cycle. A `done = 100` pulse issued while K owns the bus has no effect.
5. **Timeout:** with `ARB_TIMEOUT_EN` defined and `MAX_HOLD = 4`, N holds the bus with `req = 011`.
   - After 4 granted cycles, expect `grant = 000` and a `timeout` pulse.
   - Then `grant = 010`.
6. **Asynchronous reset mid-grant:** drop `rst_n` between clock edges during GRANT. Expect `grant = 000` immediately. After release of reset with `req = 111`, N is granted first.
